// File: rtl/alu_8bit_pkg.sv
// Shared definitions for the 8-bit accumulator ALU: data width, opcodes and
// the registered result record.
package alu_8bit_pkg;

    localparam int DATA_W = 8;
    localparam int OP_W   = 3;

    typedef enum logic [OP_W-1:0] {
        OP_HLT = 3'b000,
        OP_SKZ = 3'b001,
        OP_ADD = 3'b010,
        OP_AND = 3'b011,
        OP_XOR = 3'b100,
        OP_LDA = 3'b101,
        OP_STO = 3'b110,
        OP_JMP = 3'b111
    } alu_op_e;

    // Result bits and zero flag live in one register so they can never disagree.
    typedef struct packed {
        logic              zero;
        logic [DATA_W-1:0] data;
    } alu_res_t;

    localparam alu_res_t RES_RST = '{zero: 1'b1, data: '0};

    function automatic logic is_zero(input logic [DATA_W-1:0] v);
        return ~|v;
    endfunction

endpackage

// File: rtl/alu_8bit_if.sv
// Operand/opcode/result bundle between the ALU and its driver.
interface alu_8bit_if;
    import alu_8bit_pkg::*;

    logic [DATA_W-1:0] inA;
    logic [DATA_W-1:0] inB;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_out;
    logic              SKZ_cmp;

    modport master (output inA, output inB, output alu_op,
                    input  alu_out, input SKZ_cmp);
    modport slave  (input  inA, input inB, input alu_op,
                    output alu_out, output SKZ_cmp);
endinterface

// File: rtl/alu_8bit_adder.sv
// Ripple-carry adder: a chain of full adders, one per bit.
module adder_8bit
    import alu_8bit_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    output logic [DATA_W-1:0] sum,
    output logic              cout
);
    logic [DATA_W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < DATA_W; i++) begin : g_fa
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[DATA_W];
endmodule

// File: rtl/alu_8bit.sv
// 8-bit accumulator ALU: combinational opcode mux into a single registered
// result + zero-flag stage, one cycle latency.
module alu_8bit
    import alu_8bit_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    alu_8bit_if.slave bus
);
    logic [DATA_W-1:0] add_sum;
    logic              unused_cout;
    alu_res_t          res_d;
    alu_res_t          res_q;
    logic [DATA_W-1:0] nxt;

    // Carry out is dropped: ADD wraps modulo 256 with no overflow flag.
    adder_8bit u_add (
        .a    (bus.inA),
        .b    (bus.inB),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (unused_cout)
    );

    always_comb begin
        nxt = bus.inA;
        unique case (alu_op_e'(bus.alu_op))
            OP_ADD:  nxt = add_sum;
            OP_AND:  nxt = bus.inA & bus.inB;
            OP_XOR:  nxt = bus.inA ^ bus.inB;
            OP_LDA:  nxt = bus.inB;
            default: nxt = bus.inA;
        endcase
        res_d      = '{zero: is_zero(nxt), data: nxt};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) res_q <= RES_RST;
        else        res_q <= res_d;
    end

    assign bus.alu_out = res_q.data;
    assign bus.SKZ_cmp = res_q.zero;
endmodule

// File: tb/tb_alu_8bit.sv
// Directed self-checking bench for alu_8bit.
module tb_alu_8bit;
    import alu_8bit_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    alu_8bit_if bus();

    alu_8bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Drive one operation and sample one edge later.
    task automatic step(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        bus.alu_op = op;
        bus.inA    = a;
        bus.inB    = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step(3'(i + 2), 8'h37 + 8'(i), 8'hC9);
            checks++;
            if (bus.alu_out !== 8'h00) begin
                failures++;
                $display("FAIL reset_out[%0d] got=%h want=00", i, bus.alu_out);
            end
            checks++;
            if (bus.SKZ_cmp !== 1'b1) begin
                failures++;
                $display("FAIL reset_zero[%0d] got=%b want=1", i, bus.SKZ_cmp);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_sto_lda();
        step(3'b110, 8'hAB, 8'hFF);
        checks++;
        if (bus.alu_out !== 8'hAB || bus.SKZ_cmp !== 1'b0) begin
            failures++;
            $display("FAIL sto got=%h/%b want=ab/0", bus.alu_out, bus.SKZ_cmp);
        end
        step(3'b101, 8'h00, 8'h3C);
        checks++;
        if (bus.alu_out !== 8'h3C || bus.SKZ_cmp !== 1'b0) begin
            failures++;
            $display("FAIL lda got=%h/%b want=3c/0", bus.alu_out, bus.SKZ_cmp);
        end
    endtask

    task automatic test_logic();
        step(3'b011, 8'hF0, 8'h0F);
        checks++;
        if (bus.alu_out !== 8'h00 || bus.SKZ_cmp !== 1'b1) begin
            failures++;
            $display("FAIL and_zero got=%h/%b want=00/1", bus.alu_out, bus.SKZ_cmp);
        end
        step(3'b100, 8'hA5, 8'h5A);
        checks++;
        if (bus.alu_out !== 8'hFF || bus.SKZ_cmp !== 1'b0) begin
            failures++;
            $display("FAIL xor got=%h/%b want=ff/0", bus.alu_out, bus.SKZ_cmp);
        end
        step(3'b011, 8'hF0, 8'hFF);
        checks++;
        if (bus.alu_out !== 8'hF0 || bus.SKZ_cmp !== 1'b0) begin
            failures++;
            $display("FAIL and_f0 got=%h/%b want=f0/0", bus.alu_out, bus.SKZ_cmp);
        end
    endtask

    task automatic test_add();
        step(3'b010, 8'h0F, 8'h01);
        checks++;
        if (bus.alu_out !== 8'h10 || bus.SKZ_cmp !== 1'b0) begin
            failures++;
            $display("FAIL add_0f01 got=%h/%b want=10/0", bus.alu_out, bus.SKZ_cmp);
        end
        step(3'b010, 8'hFF, 8'h01);
        checks++;
        if (bus.alu_out !== 8'h00 || bus.SKZ_cmp !== 1'b1) begin
            failures++;
            $display("FAIL add_wrap got=%h/%b want=00/1", bus.alu_out, bus.SKZ_cmp);
        end
        step(3'b010, 8'h80, 8'h80);
        checks++;
        if (bus.alu_out !== 8'h00 || bus.SKZ_cmp !== 1'b1) begin
            failures++;
            $display("FAIL add_8080 got=%h/%b want=00/1", bus.alu_out, bus.SKZ_cmp);
        end
        step(3'b010, 8'h3C, 8'h55);
        checks++;
        if (bus.alu_out !== 8'h91 || bus.SKZ_cmp !== 1'b0) begin
            failures++;
            $display("FAIL add_3c55 got=%h/%b want=91/0", bus.alu_out, bus.SKZ_cmp);
        end
    endtask

    task automatic test_pass();
        logic [2:0] ops [3];
        ops = '{3'b000, 3'b001, 3'b111};
        for (int i = 0; i < 3; i++) begin
            step(ops[i], 8'h5A, 8'hC3);
            checks++;
            if (bus.alu_out !== 8'h5A || bus.SKZ_cmp !== 1'b0) begin
                failures++;
                $display("FAIL pass_op%0d got=%h/%b want=5a/0", ops[i], bus.alu_out, bus.SKZ_cmp);
            end
        end
        // Zero operand through a pass-through op must raise the flag.
        step(3'b000, 8'h00, 8'hC3);
        checks++;
        if (bus.alu_out !== 8'h00 || bus.SKZ_cmp !== 1'b1) begin
            failures++;
            $display("FAIL pass_zero got=%h/%b want=00/1", bus.alu_out, bus.SKZ_cmp);
        end
    endtask

    task automatic test_hold();
        step(3'b101, 8'h00, 8'h77);
        bus.alu_op = 3'b010;
        bus.inA    = 8'h01;
        bus.inB    = 8'h01;
        #3;
        checks++;
        if (bus.alu_out !== 8'h77 || bus.SKZ_cmp !== 1'b0) begin
            failures++;
            $display("FAIL hold got=%h/%b want=77/0", bus.alu_out, bus.SKZ_cmp);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.alu_out !== 8'h02) begin
            failures++;
            $display("FAIL hold_next got=%h want=02", bus.alu_out);
        end
    endtask

    task automatic test_reset_priority();
        step(3'b100, 8'hA5, 8'h00);
        rst_n = 1'b0;
        step(3'b010, 8'h0F, 8'h01);
        checks++;
        if (bus.alu_out !== 8'h00 || bus.SKZ_cmp !== 1'b1) begin
            failures++;
            $display("FAIL rst_prio got=%h/%b want=00/1", bus.alu_out, bus.SKZ_cmp);
        end
        rst_n = 1'b1;
        step(3'b010, 8'h0F, 8'h01);
        checks++;
        if (bus.alu_out !== 8'h10 || bus.SKZ_cmp !== 1'b0) begin
            failures++;
            $display("FAIL rst_release got=%h/%b want=10/0", bus.alu_out, bus.SKZ_cmp);
        end
    endtask

    initial begin
        bus.alu_op = 3'b000;
        bus.inA    = 8'h00;
        bus.inB    = 8'h00;
        #1;
        test_reset();
        test_sto_lda();
        test_logic();
        test_add();
        test_pass();
        test_hold();
        test_reset_priority();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
